// File: rtl/video_timing_vram_pkg.sv
// Shared mode defaults, derived raster constants and frame-store geometry
// for the VGA timing generator and its video RAM.
package video_pkg;

    localparam int DEF_CORDW  = 16;
    localparam int DEF_H_RES  = 848;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_H_SYNC = 112;
    localparam int DEF_H_BP   = 112;
    localparam int DEF_V_FP   = 6;
    localparam int DEF_V_SYNC = 8;
    localparam int DEF_V_BP   = 23;
    localparam bit DEF_H_POL  = 1'b1;
    localparam bit DEF_V_POL  = 1'b1;

    // Blanking sits at negative coordinates so that the active area starts at 0.
    function automatic int blank_start(input int fp, input int sync, input int bp);
        return -(fp + sync + bp);
    endfunction

    localparam int H_STA    = blank_start(DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_STA    = blank_start(DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
    localparam int HS_STA   = H_STA + DEF_H_FP;
    localparam int HS_END   = HS_STA + DEF_H_SYNC - 1;
    localparam int VS_STA   = V_STA + DEF_V_FP;
    localparam int VS_END   = VS_STA + DEF_V_SYNC - 1;
    localparam int H_TOTAL  = DEF_H_RES - H_STA;
    localparam int V_TOTAL  = DEF_V_RES - V_STA;

    localparam int DATA_W     = 32;
    localparam int BYTE_LANES = DATA_W / 8;
    localparam int DEF_SIZE   = 32768;
    localparam int DEF_AW     = $clog2(DEF_SIZE);

endpackage

// File: rtl/video_timing_vram_bram.sv
// Dual-port frame store: byte-masked read/write port A, read-only port B.
// Both read ports are registered; a same-clock read of a written word sees old data.
module bram
    import video_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_ni,
    input  logic                  sel_i,
    input  logic                  wr_en_i,
    input  logic [BYTE_LANES-1:0] wr_mask_i,
    input  logic [AW-1:0]         addr_a_i,
    input  logic [DATA_W-1:0]     data_a_i,
    output logic [DATA_W-1:0]     data_a_o,
    input  logic [AW-1:0]         addr_b_i,
    output logic [DATA_W-1:0]     data_b_o
);

    logic [DATA_W-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        if (sel_i && wr_en_i) begin
            for (int i = 0; i < BYTE_LANES; i++) begin
                if (wr_mask_i[i]) begin
                    mem[addr_a_i][8*i +: 8] <= data_a_i[8*i +: 8];
                end
            end
        end
    end

    // Output registers clear on reset; the array itself is never cleared.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            data_a_o <= '0;
            data_b_o <= '0;
        end else begin
            if (sel_i && !wr_en_i) begin
                data_a_o <= mem[addr_a_i];
            end
            data_b_o <= mem[addr_b_i];
        end
    end

endmodule

// File: rtl/video_timing_vram.sv
// VGA raster timing generator (coordinates, syncs, DE, line/frame strobes)
// combined with the CPU/pixel-fetch dual-port video RAM.
module video_timing_vram
    import video_pkg::*;
#(
    parameter int CORDW  = DEF_CORDW,
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int H_FP   = DEF_H_FP,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int V_FP   = DEF_V_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter bit H_POL  = DEF_H_POL,
    parameter bit V_POL  = DEF_V_POL,
    parameter int SIZE   = DEF_SIZE,
    parameter int AW     = $clog2(SIZE)
) (
    input  logic                    clk,
    input  logic                    reset_ni,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic                    frame,
    output logic                    line,
    input  logic                    sel_i,
    input  logic                    wr_en_i,
    input  logic [BYTE_LANES-1:0]   wr_mask_i,
    input  logic [AW-1:0]           address_in_i,
    input  logic [DATA_W-1:0]       data_in_i,
    output logic [DATA_W-1:0]       data_out_o,
    output logic                    ack_o,
    input  logic [AW-1:0]           sec_address_in_i,
    output logic [DATA_W-1:0]       sec_data_out_o
);

    localparam logic signed [CORDW-1:0] H_START  = CORDW'(blank_start(H_FP, H_SYNC, H_BP));
    localparam logic signed [CORDW-1:0] V_START  = CORDW'(blank_start(V_FP, V_SYNC, V_BP));
    localparam logic signed [CORDW-1:0] H_LAST   = CORDW'(H_RES - 1);
    localparam logic signed [CORDW-1:0] V_LAST   = CORDW'(V_RES - 1);
    localparam logic signed [CORDW-1:0] HS_FIRST = CORDW'(blank_start(H_FP, H_SYNC, H_BP) + H_FP);
    localparam logic signed [CORDW-1:0] HS_LAST  = CORDW'(blank_start(H_FP, H_SYNC, H_BP) + H_FP + H_SYNC - 1);
    localparam logic signed [CORDW-1:0] VS_FIRST = CORDW'(blank_start(V_FP, V_SYNC, V_BP) + V_FP);
    localparam logic signed [CORDW-1:0] VS_LAST  = CORDW'(blank_start(V_FP, V_SYNC, V_BP) + V_FP + V_SYNC - 1);
    localparam logic signed [CORDW-1:0] ONE      = CORDW'(1);

    logic signed [CORDW-1:0] sx_nxt;
    logic signed [CORDW-1:0] sy_nxt;

    always_comb begin
        sx_nxt = sx + ONE;
        sy_nxt = sy;
        if (sx == H_LAST) begin
            sx_nxt = H_START;
            sy_nxt = (sy == V_LAST) ? V_START : sy + ONE;
        end
    end

    // Decoded outputs are computed from the next coordinate so that every
    // timing output registers in step with sx/sy.
    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            sx    <= H_START;
            sy    <= V_START;
            hsync <= ~H_POL;
            vsync <= ~V_POL;
            de    <= 1'b0;
            frame <= 1'b1;
            line  <= 1'b1;
        end else begin
            sx    <= sx_nxt;
            sy    <= sy_nxt;
            hsync <= (sx_nxt >= HS_FIRST && sx_nxt <= HS_LAST) ? H_POL : ~H_POL;
            vsync <= (sy_nxt >= VS_FIRST && sy_nxt <= VS_LAST) ? V_POL : ~V_POL;
            de    <= !sx_nxt[CORDW-1] && !sy_nxt[CORDW-1];
            frame <= (sx_nxt == H_START) && (sy_nxt == V_START);
            line  <= (sx_nxt == H_START);
        end
    end

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            ack_o <= 1'b0;
        end else begin
            ack_o <= sel_i;
        end
    end

    bram #(
        .SIZE (SIZE),
        .AW   (AW)
    ) u_bram (
        .clk       (clk),
        .reset_ni  (reset_ni),
        .sel_i     (sel_i),
        .wr_en_i   (wr_en_i),
        .wr_mask_i (wr_mask_i),
        .addr_a_i  (address_in_i),
        .data_a_i  (data_in_i),
        .data_a_o  (data_out_o),
        .addr_b_i  (sec_address_in_i),
        .data_b_o  (sec_data_out_o)
    );

endmodule

// File: tb/tb_video_timing_vram.sv
// Bench for video_timing_vram: default-mode instance for RAM and raster checks,
// reduced-mode instance for whole-frame statistics and mid-frame reset.
module tb_video_timing_vram;

    localparam int S_HRES = 40, S_HFP = 4, S_HSW = 6, S_HBP = 10;
    localparam int S_VRES = 10, S_VFP = 2, S_VSW = 3, S_VBP = 5;
    localparam int S_HTOT = S_HRES + S_HFP + S_HSW + S_HBP;
    localparam int S_VTOT = S_VRES + S_VFP + S_VSW + S_VBP;
    localparam int S_FT   = S_HTOT * S_VTOT;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n   = 1'b1;
    logic rst_s_n = 1'b1;

    logic signed [15:0] sx, sy;
    logic        hsync, vsync, de, frame, line;
    logic        sel = 1'b0, wr = 1'b0;
    logic [3:0]  mask = '0;
    logic [14:0] addr = '0, saddr = '0;
    logic [31:0] din = '0, dout, sdout;
    logic        ack;

    logic signed [15:0] sx_s, sy_s;
    logic        hs_s, vs_s, de_s, fr_s, ln_s, ack_s;
    logic [31:0] dout_s, sdout_s;

    int     n_chk  = 0;
    int     n_pass = 0;
    int     cyc    = 0;
    longint k_d    = 0;
    longint k_s    = 0;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] shadow [16];
    bit          valid  [16];
    logic [31:0] last_dout = '0;

    video_timing_vram dut (
        .clk(clk), .reset_ni(rst_n),
        .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de), .frame(frame), .line(line),
        .sel_i(sel), .wr_en_i(wr), .wr_mask_i(mask), .address_in_i(addr), .data_in_i(din),
        .data_out_o(dout), .ack_o(ack), .sec_address_in_i(saddr), .sec_data_out_o(sdout)
    );

    video_timing_vram #(
        .H_RES(S_HRES), .V_RES(S_VRES), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
        .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP), .H_POL(1'b0), .V_POL(1'b0), .SIZE(64)
    ) dut_s (
        .clk(clk), .reset_ni(rst_s_n),
        .sx(sx_s), .sy(sy_s), .hsync(hs_s), .vsync(vs_s), .de(de_s), .frame(fr_s), .line(ln_s),
        .sel_i(1'b0), .wr_en_i(1'b0), .wr_mask_i(4'h0), .address_in_i(6'd0), .data_in_i(32'd0),
        .data_out_o(dout_s), .ack_o(ack_s), .sec_address_in_i(6'd0), .sec_data_out_o(sdout_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Raster position is k clocks after reset release, folded into the frame period.
    function automatic void tmodel(input longint k, input int hres, input int hfp, input int hsw,
                                   input int hbp, input int vres, input int vfp, input int vsw,
                                   input int vbp, input bit hpol, input bit vpol,
                                   output int ex, output int ey, output bit ehs, output bit evs,
                                   output bit ede, output bit efr, output bit eln);
        int hsta, vsta, htot, vtot;
        longint pos;
        hsta = -(hfp + hsw + hbp);
        vsta = -(vfp + vsw + vbp);
        htot = hres - hsta;
        vtot = vres - vsta;
        pos  = k % longint'(htot * vtot);
        ex   = hsta + int'(pos % htot);
        ey   = vsta + int'(pos / htot);
        ehs  = (ex >= hsta + hfp && ex <= hsta + hfp + hsw - 1) ? hpol : !hpol;
        evs  = (ey >= vsta + vfp && ey <= vsta + vfp + vsw - 1) ? vpol : !vpol;
        ede  = (ex >= 0) && (ey >= 0);
        efr  = (ex == hsta) && (ey == vsta);
        eln  = (ex == hsta);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst_n)   if (!rst_n)   k_d <= 0; else k_d <= k_d + 1;
    always @(posedge clk or negedge rst_s_n) if (!rst_s_n) k_s <= 0; else k_s <= k_s + 1;

    always @(negedge clk) begin : mon_timing
        int ex, ey;
        bit a, b, c, d, e;
        tmodel(k_d, 848, 16, 112, 112, 480, 6, 8, 23, 1'b1, 1'b1, ex, ey, a, b, c, d, e);
        chk("timing", 64'({sx, sy, hsync, vsync, de, frame, line}),
            64'({16'(ex), 16'(ey), a, b, c, d, e}));
        tmodel(k_s, S_HRES, S_HFP, S_HSW, S_HBP, S_VRES, S_VFP, S_VSW, S_VBP, 1'b0, 1'b0,
               ex, ey, a, b, c, d, e);
        chk("timing_small", 64'({sx_s, sy_s, hs_s, vs_s, de_s, fr_s, ln_s}),
            64'({16'(ex), 16'(ey), a, b, c, d, e}));
    end

    always @(negedge clk) begin : mon_ram
        exp_t e;
        bit   due_now;
        if (rst_n) begin
            due_now = (qa.size() > 0) && (qa[0].due == cyc);
            chk("ack", 64'(ack), 64'(due_now));
            if (due_now) begin
                e = qa.pop_front();
                if (ack) chk("porta_data", 64'(dout), 64'(e.data));
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                chk("portb_data", 64'(sdout), 64'(e.data));
            end
        end
    end

    task automatic op(input bit s, input bit w, input logic [3:0] m, input int a,
                      input logic [31:0] d, input int b);
        sel = s; wr = w; mask = m; addr = 15'(a); din = d; saddr = 15'(b);
        if (valid[b]) qb.push_back('{cyc + 1, shadow[b]});
        if (s) begin
            if (!w) last_dout = shadow[a];
            qa.push_back('{cyc + 1, last_dout});
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (m[i]) shadow[a][8*i +: 8] = d[8*i +: 8];
                if (m == 4'hF) valid[a] = 1'b1;
            end
        end
        @(posedge clk); #1;
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic chk_reset_default(input string tag);
        chk({tag, "_sx"},    64'(sx),    64'(-240));
        chk({tag, "_sy"},    64'(sy),    64'(-37));
        chk({tag, "_frame"}, 64'(frame), 64'(1));
        chk({tag, "_line"},  64'(line),  64'(1));
        chk({tag, "_de"},    64'(de),    64'(0));
        chk({tag, "_hsync"}, 64'(hsync), 64'(0));
        chk({tag, "_vsync"}, 64'(vsync), 64'(0));
        chk({tag, "_ack"},   64'(ack),   64'(0));
        chk({tag, "_dout"},  64'(dout),  64'(0));
        chk({tag, "_sdout"}, 64'(sdout), 64'(0));
    endtask

    task automatic run_default();
        int i;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_default("rst");
        #2 rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("hs_before_sx", 64'(sx), 64'(-225));
        chk("hs_before",    64'(hsync), 64'(0));
        @(posedge clk); #1;
        chk("hs_rise_sx", 64'(sx), 64'(-224));
        chk("hs_rise",    64'(hsync), 64'(1));

        op(1'b1, 1'b1, 4'hF, 5, 32'hDEADBEEF, 0);
        op(1'b1, 1'b0, 4'h0, 5, 32'h0, 0);
        chk("rd_full", 64'(dout), 64'(32'hDEADBEEF));
        chk("rd_ack",  64'(ack),  64'(1));
        op(1'b1, 1'b1, 4'b0101, 5, 32'h11223344, 0);
        op(1'b1, 1'b0, 4'h0, 5, 32'h0, 0);
        chk("rd_masked", 64'(dout), 64'(32'hDE22BE44));
        op(1'b1, 1'b1, 4'hF, 5, 32'h0, 5);
        chk("collide_old", 64'(sdout), 64'(32'hDE22BE44));
        op(1'b0, 1'b0, 4'h0, 0, 32'h0, 5);
        chk("collide_new", 64'(sdout), 64'(0));

        for (int a = 0; a < 16; a++) op(1'b1, 1'b1, 4'hF, a, $urandom, $urandom_range(0, 15));
        repeat (300) begin
            if ($urandom_range(0, 4) == 0) op(1'b0, 1'b0, 4'h0, 0, 32'h0, $urandom_range(0, 15));
            else op(1'b1, 1'($urandom), 4'($urandom), $urandom_range(0, 15), $urandom,
                    $urandom_range(0, 15));
        end

        i = 0;
        while (sy != -16'sd22 && i < 20000) begin
            @(posedge clk); #1;
            i++;
        end
        chk("reach_sy", 64'(sy), 64'(-22));

        // Read in flight when reset hits mid-frame: its ack must never appear.
        sel = 1'b1; wr = 1'b0; addr = 15'd5;
        #3;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        last_dout = '0;
        #1;
        chk_reset_default("midrst");
        @(posedge clk); #1;
        chk("midrst_ack_held", 64'(ack),  64'(0));
        chk("midrst_dout",     64'(dout), 64'(0));
        sel = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        op(1'b1, 1'b0, 4'h0, 5, 32'h0, 5);
        chk("retained", 64'(dout), 64'(shadow[5]));
        repeat (4) @(posedge clk);
    endtask

    task automatic run_small();
        int t0, t1, t2, fseen, decnt, lncnt;
        t0 = 0; t1 = 0; t2 = 0; fseen = 0; decnt = 0; lncnt = 0;
        rst_s_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_s_n = 1'b1;
        for (int i = 0; i < 2 * S_FT + 2; i++) begin
            @(negedge clk);
            if (fr_s) begin
                if (fseen == 0) t0 = i;
                else if (fseen == 1) t1 = i;
                else if (fseen == 2) t2 = i;
                fseen++;
            end
            if (fseen == 1) begin
                decnt += int'(de_s);
                lncnt += int'(ln_s);
            end
        end
        chk("frames_seen",   64'(fseen),   64'(3));
        chk("frame_period1", 64'(t1 - t0), 64'(S_FT));
        chk("frame_period2", 64'(t2 - t1), 64'(S_FT));
        chk("de_per_frame",  64'(decnt),   64'(S_HRES * S_VRES));
        chk("lines_frame",   64'(lncnt),   64'(S_VTOT));

        repeat ($urandom_range(100, 900)) @(posedge clk);
        #3 rst_s_n = 1'b0;
        #1;
        chk("s_rst_sx",    64'(sx_s), 64'(-20));
        chk("s_rst_sy",    64'(sy_s), 64'(-10));
        chk("s_rst_frame", 64'(fr_s), 64'(1));
        chk("s_rst_line",  64'(ln_s), 64'(1));
        chk("s_rst_de",    64'(de_s), 64'(0));
        chk("s_rst_hsync", 64'(hs_s), 64'(1));
        chk("s_rst_vsync", 64'(vs_s), 64'(1));
        #3 rst_s_n = 1'b1;
        repeat (200) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            valid[i]  = 1'b0;
            shadow[i] = '0;
        end
        fork
            run_default();
            run_small();
        join
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
